// File: rtl/mem_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_rr_arbiter_if
//   Bundles every signal between mem_rr_arbiter, its requesters and the shared
//   single-port memory. Clock and reset are plain module ports, not part of
//   the bundle.
//
//   Requester side (packed, requester k in slice k):
//     req_valid  N_REQ             request valid, held until req_ready
//     req_wr_rd  N_REQ             1=write, 0=read
//     req_addr   N_REQ*ADDR_WIDTH  word address
//     req_wdata  N_REQ*WIDTH       write data
//     req_ready  N_REQ             one-hot accept pulse
//     rsp_valid  N_REQ             one-hot completion pulse
//     rsp_err    1                 1=memory timed out
//     rsp_rdata  WIDTH             read data (0 for writes and errors)
//   Memory side:
//     mem_valid, mem_wr_rd, mem_addr, mem_wdata   command to memory
//     mem_ready, mem_rdata                        answer from memory
//
//   Modports:
//     master  - the arbiter's view
//     slave   - the requesters' and memory's view
// ----------------------------------------------------------------------------
interface mem_rr_arbiter_if #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 9
);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_wr_rd;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*WIDTH-1:0]      req_wdata;
    logic [N_REQ-1:0]            req_ready;

    logic [N_REQ-1:0]            rsp_valid;
    logic                        rsp_err;
    logic [WIDTH-1:0]            rsp_rdata;

    logic                        mem_valid;
    logic                        mem_wr_rd;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic [WIDTH-1:0]            mem_wdata;
    logic                        mem_ready;
    logic [WIDTH-1:0]            mem_rdata;

    modport master (
        input  req_valid,
        input  req_wr_rd,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_err,
        output rsp_rdata,
        output mem_valid,
        output mem_wr_rd,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        output req_valid,
        output req_wr_rd,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_err,
        input  rsp_rdata,
        input  mem_valid,
        input  mem_wr_rd,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/mem_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mem_rr_arbiter
//   Round-robin arbiter sharing one single-port WIDTH x DEPTH memory between
//   N_REQ requesters. One request is accepted at a time: its command is
//   latched, presented to the memory with a one-cycle valid, and the arbiter
//   then waits for the memory ready. The granted requester receives a
//   one-cycle response pulse carrying read data, or an error flag if the
//   memory stays silent for TIMEOUT cycles.
//
//   Ports:
//     clk_i  clock, all state on the rising edge
//     rst_i  asynchronous, active-high reset
//     bus    mem_rr_arbiter_if.master (requester and memory signals)
//
//   Timing for a memory that answers in the cycle after valid:
//     cycle 0  IDLE   req_ready pulse, command latched at the edge
//     cycle 1  ISSUE  mem_valid high
//     cycle 2  WAIT   mem_ready seen
//     cycle 3  IDLE   rsp_valid pulse; a new request may be accepted here
// ----------------------------------------------------------------------------
module mem_rr_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_rr_arbiter_if.master  bus
);

    // Grant index width and timeout counter width (counter never exceeds TIMEOUT-1).
    localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e                state_q, state_d;
    logic [GW-1:0]         last_gnt_q, last_gnt_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  cmd_wr_q, cmd_wr_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [WIDTH-1:0]      cmd_wdata_q, cmd_wdata_d;

    logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;

    logic                  gnt_found;
    logic [GW-1:0]         gnt_idx;

    // ------------------------------------------------------------------------
    // Round-robin pick: scan last_gnt+1, last_gnt+2, ... wrapping at N_REQ.
    // The last candidate examined is last_gnt itself, so a lone requester
    // can be granted back to back.
    // ------------------------------------------------------------------------
    always_comb begin
        int unsigned idx;
        logic [GW-1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx  = (32'(last_gnt_q) + i) % N_REQ;
            cand = GW'(idx);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Accept pulse exists only while idle.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == StIdle && gnt_found) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        cnt_d       = cnt_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rsp_valid_d = '0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    cmd_wr_d    = bus.req_wr_rd[gnt_idx];
                    cmd_addr_d  = bus.req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    cmd_wdata_d = bus.req_wdata[gnt_idx*WIDTH +: WIDTH];
                    last_gnt_d  = gnt_idx;
                    state_d     = StIssue;
                end
            end

            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end

            StWait: begin
                if (bus.mem_ready) begin
                    rsp_valid_d[last_gnt_q] = 1'b1;
                    rsp_err_d               = 1'b0;
                    rsp_rdata_d             = cmd_wr_q ? '0 : bus.mem_rdata;
                    state_d                 = StIdle;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_valid_d[last_gnt_q] = 1'b1;
                    rsp_err_d               = 1'b1;
                    rsp_rdata_d             = '0;
                    state_d                 = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            last_gnt_q  <= GW'(N_REQ - 1);
            cnt_q       <= '0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. mem_valid is decoded from state so an asynchronous reset
    // removes it immediately; the command fields hold in every state.
    // ------------------------------------------------------------------------
    always_comb begin
        bus.mem_valid = (state_q == StIssue);
        bus.mem_wr_rd = cmd_wr_q;
        bus.mem_addr  = cmd_addr_q;
        bus.mem_wdata = cmd_wdata_q;
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_err   = rsp_err_q;
        bus.rsp_rdata = rsp_rdata_q;
    end

    // ------------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------------
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(bus.req_ready));

    a_rsp_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(bus.rsp_valid));

    a_mem_valid_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.mem_valid |=> !bus.mem_valid);

endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;

    localparam int unsigned N_REQ      = 2;
    localparam int unsigned WIDTH      = 16;
    localparam int unsigned DEPTH      = 512;
    localparam int unsigned ADDR_WIDTH = 9;
    localparam int unsigned TIMEOUT    = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_rr_arbiter_if #(
        .N_REQ      (N_REQ),
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) bus ();

    mem_rr_arbiter #(
        .N_REQ      (N_REQ),
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Memory model: answers in the cycle after valid unless mem_en is low.
    logic [WIDTH-1:0] mem [DEPTH];
    logic             mem_en;

    always @(posedge clk) begin
        if (rst) begin
            bus.mem_ready <= 1'b0;
        end else begin
            bus.mem_ready <= bus.mem_valid && mem_en;
            if (bus.mem_valid) begin
                if (bus.mem_wr_rd) mem[bus.mem_addr] <= bus.mem_wdata;
                else               bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [N_REQ-1:0] id;
        logic             err;
        logic [WIDTH-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every response pulse is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_valid", 32'(bus.rsp_valid), 32'(e.id));
                check("rsp_err",   32'(bus.rsp_err),   32'(e.err));
                check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
            end
        end
    end

    task automatic do_req(input int k, input logic wr, input logic [ADDR_WIDTH-1:0] addr,
                          input logic [WIDTH-1:0] wdata, input logic push,
                          input logic err, input logic [WIDTH-1:0] rdata);
        logic got;
        got = 1'b0;
        @(negedge clk);
        bus.req_wr_rd[k]                        = wr;
        bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = addr;
        bus.req_wdata[k*WIDTH +: WIDTH]          = wdata;
        bus.req_valid[k]                        = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            #1;
            if (bus.req_ready[k]) got = 1'b1;
            else @(negedge clk);
        end
        check("accept", 32'(got), 32'h1);
        if (got) begin
            check("ready_onehot", 32'(bus.req_ready), 32'(1 << k));
            if (push) exp_q.push_back('{id: N_REQ'(1 << k), err: err, rdata: rdata});
            @(posedge clk);
            #1;
            check("issue_valid", 32'(bus.mem_valid), 32'h1);
            check("issue_addr",  32'(bus.mem_addr),  32'(addr));
            check("issue_wr_rd", 32'(bus.mem_wr_rd), 32'(wr));
            if (wr) check("issue_wdata", 32'(bus.mem_wdata), 32'(wdata));
            check("ready_busy", 32'(bus.req_ready), 32'h0);
        end
        bus.req_valid[k] = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gcount, last_c, n, bad;
        logic got;

        bus.req_valid = '0;
        bus.req_wr_rd = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        mem_en        = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: write with latency check
        do_req(0, 1'b1, 9'd5, 16'hABCD, 1'b1, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        check("t1_valid_drop", 32'(bus.mem_valid), 32'h0);
        check("t1_no_rsp_yet", 32'(bus.rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        check("t1_rsp_latency", 32'(bus.rsp_valid), 32'h1);
        wait_drain();

        // 2: read back
        do_req(0, 1'b0, 9'd5, 16'h0000, 1'b1, 1'b0, 16'hABCD);
        wait_drain();

        // 3: both requesters held, strict alternation starting at 0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_wr_rd = 2'b00;
        bus.req_addr  = {9'd5, 9'd5};
        bus.req_valid = 2'b11;
        gcount = 0;
        last_c = 0;
        for (int c = 0; c < 60 && gcount < 4; c++) begin
            #1;
            if (bus.req_ready != '0) begin
                check("t3_grant", 32'(bus.req_ready), (gcount % 2 == 0) ? 32'h1 : 32'h2);
                if (gcount > 0) check("t3_gap", 32'(c - last_c), 32'h3);
                exp_q.push_back('{id: (gcount % 2 == 0) ? 2'b01 : 2'b10, err: 1'b0,
                                  rdata: 16'hABCD});
                last_c = c;
                gcount++;
            end
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        check("t3_grants", 32'(gcount), 32'h4);
        wait_drain();

        // 4: timeout
        mem_en = 1'b0;
        do_req(1, 1'b0, 9'd3, 16'h0000, 1'b1, 1'b1, 16'h0000);
        got = 1'b0;
        for (n = 1; n <= 40 && !got; n++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid != '0) begin
                got = 1'b1;
                check("t4_latency", 32'(n), 32'(TIMEOUT + 1));
            end
        end
        check("t4_rsp_seen", 32'(got), 32'h1);
        wait_drain();
        mem_en = 1'b1;

        // 5: reset while waiting
        mem_en = 1'b0;
        do_req(0, 1'b0, 9'd5, 16'h0000, 1'b0, 1'b0, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_mem_valid", 32'(bus.mem_valid), 32'h0);
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_en = 1'b1;
        bad = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0 || bus.mem_valid) bad++;
        end
        check("t5_silent", 32'(bad), 32'h0);
        bus.req_wr_rd = 2'b00;
        bus.req_addr  = {9'd5, 9'd5};
        bus.req_valid = 2'b11;
        #1;
        check("t5_first_grant", 32'(bus.req_ready), 32'h1);
        exp_q.push_back('{id: 2'b01, err: 1'b0, rdata: 16'hABCD});
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        wait_drain();

        // 6: top address
        do_req(1, 1'b1, 9'd511, 16'hFFFF, 1'b1, 1'b0, 16'h0000);
        wait_drain();
        do_req(1, 1'b0, 9'd511, 16'h0000, 1'b1, 1'b0, 16'hFFFF);
        wait_drain();

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
